// File: rtl/fpu_pipe_ctl_if.sv
// Decode-to-FP-pipeline control bus: the instruction entering E1 and the
// E1/E2/E3 stage tags and div/sqrt hold status coming back.
interface fpu_pipe_ctl_if;
    logic [2:0] fc;
    logic       wf;
    logic [4:0] fd;
    logic [4:0] e1n;
    logic [4:0] e2n;
    logic [4:0] e3n;
    logic       e1w;
    logic       e2w;
    logic       e3w;
    logic [2:0] e1c;
    logic [2:0] e2c;
    logic [2:0] e3c;
    logic       stall_div_sqrt;
    logic [4:0] ds_cnt;

    modport slave (
        input  fc, wf, fd,
        output e1n, e2n, e3n, e1w, e2w, e3w, e1c, e2c, e3c,
        output stall_div_sqrt, ds_cnt
    );

    modport master (
        output fc, wf, fd,
        input  e1n, e2n, e3n, e1w, e2w, e3w, e1c, e2c, e3c,
        input  stall_div_sqrt, ds_cnt
    );
endinterface

// File: rtl/fpu_pipe_ctl.sv
// FP pipeline control: tracks destination/write/op tags through E1..E3 and
// holds the whole FP pipe while a div or sqrt iterates in E1.
module fpu_pipe_ctl #(
    parameter int DIV_CYCLES  = 12,
    parameter int SQRT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           clr,
    fpu_pipe_ctl_if.slave  bus
);
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_SQRT = 3'b110;
    localparam logic [4:0] DIV_N   = 5'(DIV_CYCLES);
    localparam logic [4:0] SQRT_N  = 5'(SQRT_CYCLES);

    typedef struct packed {
        logic       w;
        logic [4:0] n;
        logic [2:0] c;
    } stage_t;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    stage_t     e1_q, e2_q, e3_q;
    stage_t     e1_d, e2_d, e3_d;
    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       stall;
    logic       shift;
    logic       ds_start;

    function automatic logic is_ds(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

    // The hold is raised only while the multi-cycle op itself sits in E1.
    assign stall    = e1_q.w & is_ds(e1_q.c) & (cnt_q != 5'd0);
    assign shift    = ~stall;
    assign ds_start = shift & bus.wf & is_ds(bus.fc);

    // Next stage contents: advance all three stages together or hold them all.
    always_comb begin
        e1_d = e1_q;
        e2_d = e2_q;
        e3_d = e3_q;
        if (shift) begin
            e1_d = '{w: bus.wf, n: bus.fd, c: bus.fc};
            e2_d = e1_q;
            e3_d = e2_q;
        end
    end

    // Stage tag registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            e1_q <= '0;
            e2_q <= '0;
            e3_q <= '0;
        end else begin
            e1_q <= e1_d;
            e2_q <= e2_d;
            e3_q <= e3_d;
        end
    end

    // Iteration FSM next state: a new div/sqrt loads its own count on the same
    // edge that lets it into E1, so back-to-back ops chain without a gap edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ds_start) begin
                    cnt_d   = (bus.fc == OP_DIV) ? DIV_N : SQRT_N;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (ds_start) begin
                    cnt_d   = (bus.fc == OP_DIV) ? DIV_N : SQRT_N;
                    state_d = ITER;
                end else if (cnt_q != 5'd0) begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = (cnt_q == 5'd1) ? IDLE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Iteration FSM state and remaining-count register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.e1n            = e1_q.n;
    assign bus.e1w            = e1_q.w;
    assign bus.e1c            = e1_q.c;
    assign bus.e2n            = e2_q.n;
    assign bus.e2w            = e2_q.w;
    assign bus.e2c            = e2_q.c;
    assign bus.e3n            = e3_q.n;
    assign bus.e3w            = e3_q.w;
    assign bus.e3c            = e3_q.c;
    assign bus.ds_cnt         = cnt_q;
    assign bus.stall_div_sqrt = stall;
endmodule

// File: tb/tb_fpu_pipe_ctl.sv
// Bench for fpu_pipe_ctl: a decode emulator feeds an instruction queue and a
// residency-based model predicts every stage tag, the count and the hold.
module tb_fpu_pipe_ctl;
    localparam int DIV_N  = 12;
    localparam int SQRT_N = 16;

    typedef struct packed {
        logic       w;
        logic [4:0] d;
        logic [2:0] c;
    } instr_t;

    logic clk;
    logic clr;

    fpu_pipe_ctl_if bus();

    fpu_pipe_ctl #(.DIV_CYCLES(DIV_N), .SQRT_CYCLES(SQRT_N)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks;
    int     n_fail;
    instr_t pend[$];
    instr_t m_st[3];
    int     m_res;   // cycles the instruction now in E1 still has to spend there

    // Time an instruction spends in E1: N+1 for a real div/sqrt, else 1.
    function automatic int hold_of(input instr_t i);
        if (i.w && i.c == 3'b100) return DIV_N + 1;
        if (i.w && i.c == 3'b110) return SQRT_N + 1;
        return 1;
    endfunction

    function automatic logic [32:0] obs();
        return {bus.e1w, bus.e1n, bus.e1c, bus.e2w, bus.e2n, bus.e2c,
                bus.e3w, bus.e3n, bus.e3c, bus.ds_cnt, bus.stall_div_sqrt};
    endfunction

    function automatic logic [32:0] expv();
        logic [4:0] cnt;
        logic       st;
        cnt = 5'(m_res - 1);
        st  = (m_res > 1);
        return {m_st[0].w, m_st[0].d, m_st[0].c, m_st[1].w, m_st[1].d, m_st[1].c,
                m_st[2].w, m_st[2].d, m_st[2].c, cnt, st};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_st[i] = '0;
        m_res = 1;
        pend.delete();
    endtask

    // One clock of decode emulation: present the head of the queue, clock,
    // and retire it into the model if the pipe advanced.
    task automatic step();
        instr_t cur;
        cur = (pend.size() != 0) ? pend[0] : instr_t'('0);
        bus.wf = cur.w;
        bus.fd = cur.d;
        bus.fc = cur.c;
        @(posedge clk);
        if (m_res <= 1) begin
            m_st[2] = m_st[1];
            m_st[1] = m_st[0];
            m_st[0] = cur;
            m_res   = hold_of(cur);
            if (pend.size() != 0) void'(pend.pop_front());
        end else begin
            m_res--;
        end
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((pend.size() != 0 || m_res > 1) && guard < 200) begin
            step();
            guard++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.wf = 1'b1; bus.fd = 5'd31; bus.fc = 3'b100;
        #3;
        n_checks++;
        if (obs() !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_async obs=%h exp=0", obs());
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_held obs=%h exp=0", obs());
        end
        clr = 1'b0;
        m_reset();
    endtask

    task automatic test_single();
        pend.push_back('{w: 1'b1, d: 5'd3, c: 3'b000});
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL single_model edge=%0d obs=%h exp=%h", k, obs(), expv());
            end
            n_checks++;
            if (bus.stall_div_sqrt !== 1'b0) begin
                n_fail++;
                $display("FAIL single_stall edge=%0d obs=%b exp=0", k, bus.stall_div_sqrt);
            end
            if (k == 1) begin
                n_checks++;
                if ({bus.e1w, bus.e1n} !== {1'b1, 5'd3}) begin
                    n_fail++;
                    $display("FAIL single_e1 obs=%b/%0d exp=1/3", bus.e1w, bus.e1n);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (bus.e2n !== 5'd3) begin
                    n_fail++;
                    $display("FAIL single_e2 obs=%0d exp=3", bus.e2n);
                end
            end
            if (k == 3) begin
                n_checks++;
                if ({bus.e3w, bus.e3n} !== {1'b1, 5'd3}) begin
                    n_fail++;
                    $display("FAIL single_e3 obs=%b/%0d exp=1/3", bus.e3w, bus.e3n);
                end
            end
            if (k == 4) begin
                n_checks++;
                if ({bus.e1w, bus.e2w, bus.e3w} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL single_drain obs=%b exp=000", {bus.e1w, bus.e2w, bus.e3w});
                end
            end
        end
    endtask

    task automatic test_div();
        pend.push_back('{w: 1'b1, d: 5'd5, c: 3'b100});
        for (int k = 1; k <= 14; k++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL div_model edge=%0d obs=%h exp=%h", k, obs(), expv());
            end
            if (k == 1) begin
                n_checks++;
                if ({bus.ds_cnt, bus.stall_div_sqrt} !== {5'd12, 1'b1}) begin
                    n_fail++;
                    $display("FAIL div_load cnt=%0d stall=%b exp=12/1", bus.ds_cnt, bus.stall_div_sqrt);
                end
            end
            if (k <= 12) begin
                n_checks++;
                if (bus.stall_div_sqrt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL div_stall edge=%0d obs=%b exp=1", k, bus.stall_div_sqrt);
                end
            end
            if (k == 13) begin
                n_checks++;
                if ({bus.ds_cnt, bus.stall_div_sqrt, bus.e1n} !== {5'd0, 1'b0, 5'd5}) begin
                    n_fail++;
                    $display("FAIL div_done cnt=%0d stall=%b e1n=%0d exp=0/0/5", bus.ds_cnt, bus.stall_div_sqrt, bus.e1n);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (bus.e2n !== 5'd5) begin
                    n_fail++;
                    $display("FAIL div_e2 obs=%0d exp=5", bus.e2n);
                end
            end
        end
    endtask

    task automatic test_sqrt_add();
        pend.push_back('{w: 1'b1, d: 5'd7, c: 3'b110});
        pend.push_back('{w: 1'b1, d: 5'd8, c: 3'b000});
        for (int k = 1; k <= 18; k++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL sqrt_model edge=%0d obs=%h exp=%h", k, obs(), expv());
            end
            if (k <= 17) begin
                n_checks++;
                if (bus.e1n !== 5'd7) begin
                    n_fail++;
                    $display("FAIL sqrt_e1 edge=%0d obs=%0d exp=7", k, bus.e1n);
                end
            end else begin
                n_checks++;
                if ({bus.e1n, bus.e2n, bus.e2w, bus.e3w} !== {5'd8, 5'd7, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL sqrt_release e1n=%0d e2n=%0d e2w=%b e3w=%b exp=8/7/1/0",
                             bus.e1n, bus.e2n, bus.e2w, bus.e3w);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        pend.push_back('{w: 1'b1, d: 5'd4, c: 3'b100});
        pend.push_back('{w: 1'b1, d: 5'd6, c: 3'b110});
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL b2b_model edge=%0d obs=%h exp=%h", k, obs(), expv());
            end
            if (k == 14) begin
                n_checks++;
                if ({bus.e1n, bus.e1c, bus.ds_cnt, bus.stall_div_sqrt, bus.e2n} !==
                    {5'd6, 3'b110, 5'd16, 1'b1, 5'd4}) begin
                    n_fail++;
                    $display("FAIL b2b_chain e1n=%0d e1c=%b cnt=%0d stall=%b e2n=%0d exp=6/110/16/1/4",
                             bus.e1n, bus.e1c, bus.ds_cnt, bus.stall_div_sqrt, bus.e2n);
                end
            end
            if (k > 14) begin
                n_checks++;
                if (bus.stall_div_sqrt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_stall edge=%0d obs=%b exp=1", k, bus.stall_div_sqrt);
                end
            end
        end
    endtask

    task automatic test_bubble();
        pend.push_back('{w: 1'b0, d: 5'd10, c: 3'b100});
        pend.push_back('{w: 1'b0, d: 5'd11, c: 3'b110});
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if ({bus.ds_cnt, bus.stall_div_sqrt} !== 6'd0) begin
                n_fail++;
                $display("FAIL bubble edge=%0d cnt=%0d stall=%b exp=0/0", k, bus.ds_cnt, bus.stall_div_sqrt);
            end
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bubble_model edge=%0d obs=%h exp=%h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_clr_mid();
        pend.push_back('{w: 1'b1, d: 5'd2, c: 3'b100});
        repeat (7) step();
        n_checks++;
        if (bus.ds_cnt !== 5'd6) begin
            n_fail++;
            $display("FAIL clr_pre cnt=%0d exp=6", bus.ds_cnt);
        end
        clr = 1'b1;
        #1;
        n_checks++;
        if (obs() !== 33'd0) begin
            n_fail++;
            $display("FAIL clr_async obs=%h exp=0", obs());
        end
        #1;
        clr = 1'b0;
        m_reset();
        pend.push_back('{w: 1'b1, d: 5'd9, c: 3'b010});
        step();
        n_checks++;
        if ({bus.e1w, bus.e1n, bus.e1c} !== {1'b1, 5'd9, 3'b010}) begin
            n_fail++;
            $display("FAIL clr_resume e1=%b/%0d/%b exp=1/9/010", bus.e1w, bus.e1n, bus.e1c);
        end
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL clr_model obs=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        int     guard;
        int     r;
        instr_t ins;
        for (int i = 0; i < 120; i++) begin
            r     = int'($urandom_range(0, 19));
            ins.w = 1'($urandom_range(0, 3) != 0);
            ins.d = 5'($urandom_range(0, 31));
            if (r < 2)      ins.c = 3'b100;
            else if (r < 3) ins.c = 3'b110;
            else begin
                ins.c = 3'($urandom_range(0, 7));
                if (ins.c == 3'b100 || ins.c == 3'b110) ins.w = 1'b0;
            end
            pend.push_back(ins);
        end
        guard = 0;
        while (pend.size() != 0 && guard < 5000) begin
            step();
            guard++;
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d obs=%h exp=%h", guard, obs(), expv());
            end
        end
        n_checks++;
        if (pend.size() != 0) begin
            n_fail++;
            $display("FAIL random_timeout left=%0d exp=0", pend.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.wf   = 1'b0;
        bus.fd   = 5'd0;
        bus.fc   = 3'b000;
        m_reset();
        test_reset();
        test_single();
        drain();
        test_div();
        drain();
        test_sqrt_add();
        drain();
        test_back_to_back();
        drain();
        test_bubble();
        drain();
        test_clr_mid();
        drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_pipe_ctl.md
FPU_PIPE_CTL -- requirements
Module: fpu_pipe_ctl

Interface
REQ-001 SHALL have parameters: DIV_CYCLES, default 12, number of extra hold cycles for fdiv in E1; SQRT_CYCLES, default 16, number of extra hold cycles for fsqrt in E1; both in range 1..31.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port fc, input, 3, FP op from decode (000 add, 001 sub, 010 mul, 100 div, 110 sqrt); already zeroed by decode on stall.
REQ-005 SHALL have port wf, input, 1, FP register write enable from decode (i_fs & wpcir).
REQ-006 SHALL have port fd, input, 5, FP destination register number from decode.
REQ-007 SHALL have ports e1n, e2n, e3n, output, 5 each, destination register numbers in E1/E2/E3.
REQ-008 SHALL have ports e1w, e2w, e3w, output, 1 each, write-valid flags in E1/E2/E3.
REQ-009 SHALL have ports e1c, e2c, e3c, output, 3 each, op codes in E1/E2/E3.
REQ-010 SHALL have port stall_div_sqrt, output, 1, pipeline hold request to decode control.
REQ-011 SHALL have port ds_cnt, output, 5, remaining hold cycles of the active div/sqrt.

Function
REQ-012 SHALL define shift = ~stall_div_sqrt.
REQ-013 On a clock edge with shift=1: E1 <= {wf, fd, fc}; E2 <= E1; E3 <= E2, with n/w/c fields moving together.
REQ-014 On a clock edge with shift=0: E1, E2 and E3 SHALL all hold their values; a repeated e3w write of the same data is permitted.
REQ-015 SHALL define ds_start = shift & wf & (fc==100 | fc==110).
REQ-016 On a ds_start edge, ds_cnt SHALL load DIV_CYCLES for fc=100 or SQRT_CYCLES for fc=110.
REQ-017 When not loading and ds_cnt!=0, ds_cnt SHALL decrement by 1 per edge; it SHALL hold at 0 and never wrap below 0.
REQ-018 stall_div_sqrt SHALL be combinational: e1w & (e1c==100 | e1c==110) & (ds_cnt!=0).
REQ-019 A div/sqrt SHALL occupy E1 for exactly N+1 cycles, where N is the loaded count; stall_div_sqrt SHALL be high for the first N of those cycles.
REQ-020 An instruction with wf=0 (bubble) SHALL never start a count, whatever the value of fc.
REQ-021 Back-to-back div/sqrt: the second SHALL enter E1 on the edge that releases the first and SHALL load its own count on that same edge.
REQ-022 Stage outputs SHALL be registered; no input SHALL combinationally reach e*n, e*w or e*c.
REQ-023 States: IDLE (ds_cnt==0), ITER (ds_cnt!=0). IDLE->ITER on ds_start. ITER->IDLE when ds_cnt reaches 0. ITER->ITER on decrement.

Reset
REQ-024 While clr=1, e1n/e2n/e3n SHALL be 0, e1w/e2w/e3w SHALL be 0, e1c/e2c/e3c SHALL be 000, ds_cnt SHALL be 0 and stall_div_sqrt SHALL be 0; this applies immediately, without waiting for a clock edge.
REQ-025 clr asserted mid-ITER SHALL abort the operation; after clr deasserts, the first edge SHALL shift normally.

Verification
REQ-026 Reset, then wf=1, fd=3, fc=000 for one cycle, then bubbles -> e1n=3/e1w=1 after edge 1, e2n=3 after edge 2, e3n=3/e3w=1 after edge 3, all w=0 after edge 4, stall_div_sqrt=0 throughout.
REQ-027 fdiv (wf=1, fd=5, fc=100) with DIV_CYCLES=12 -> after edge 1: ds_cnt=12 and stall=1; stall stays high 12 cycles; ds_cnt reaches 0 at edge 13; e2n=5 at edge 14.
REQ-028 fsqrt fd=7 immediately followed by fadd fd=8 (fadd held at decode by stall) -> fsqrt stays in E1 for 17 cycles, then fadd enters E1 on the release edge; E2 shows 7 at that edge with no duplicate entry.
REQ-029 fdiv immediately followed by fsqrt -> the fsqrt enters E1 on the fdiv release edge with ds_cnt=16 and stall remaining continuously high.
REQ-030 Bubble with wf=0, fc=100 -> ds_cnt stays 0 and stall_div_sqrt=0.
REQ-031 clr pulsed while ds_cnt=6 -> all outputs 0 asynchronously; the next instruction (wf=1, fd=9, fc=010) appears at e1n=9 after the first edge following release.
